// File: rtl/inst_fetch_mem_pkg.sv
// Shared constants and address checks for the synchronous instruction fetch memory.
package inst_fetch_mem_pkg;

    localparam logic [31:0] FillWordDefault = 32'hFC000000;  // HALT encoding
    localparam logic [31:0] NopWord         = 32'h00000000;

    // True when addr is word aligned and lies inside a memory of 2**idx_w words.
    function automatic logic addr_ok(input logic [31:0] addr, input int unsigned idx_w);
        logic [31:0] hi;
        hi = addr >> (idx_w + 2);
        return (addr[1:0] == 2'b00) && (hi == 32'd0);
    endfunction

endpackage

// File: rtl/inst_mem_array.sv
// Single-write/single-read synchronous RAM, DEPTH x 32, filled with FillWord at elaboration.
module inst_mem_array #(
    parameter int unsigned Depth    = 128,
    parameter int unsigned IdxW     = 7,
    parameter logic [31:0] FillWord = 32'hFC000000
) (
    input  logic            clk_i,
    input  logic            we_i,
    input  logic [IdxW-1:0] waddr_i,
    input  logic [31:0]     wdata_i,
    input  logic            re_i,
    input  logic [IdxW-1:0] raddr_i,
    output logic [31:0]     rdata_o
);

    logic [31:0] mem_q [Depth] = '{default: FillWord};
    logic [31:0] rdata_q = FillWord;

    // Read samples the pre-edge contents, so a same-index write returns the old word.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/inst_fetch_mem.sv
// Registered instruction fetch memory with request/stall handshake, program-load port,
// alignment/range fault detection and a wrapping fetch counter.
module inst_fetch_mem
    import inst_fetch_mem_pkg::*;
#(
    parameter int unsigned Depth    = 128,
    parameter int unsigned IdxW     = 7,
    parameter logic [31:0] FillWord = FillWordDefault,
    parameter int unsigned CntW     = 16
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [31:0]     address_i,
    input  logic            fetch_req_i,
    input  logic            stall_i,
    input  logic            prog_write_i,
    input  logic [31:0]     prog_addr_i,
    input  logic [31:0]     prog_data_i,
    output logic [31:0]     instruction_o,
    output logic            inst_valid_o,
    output logic            addr_fault_o,
    output logic [CntW-1:0] fetch_count_o
);

    logic            fetch_go;
    logic            write_go;
    logic [31:0]     ram_rdata;

    logic            valid_q, valid_d;
    logic            fault_q, fault_d;
    logic            blank_q, blank_d;
    logic [CntW-1:0] count_q, count_d;

    assign fetch_go = fetch_req_i & ~stall_i;
    assign write_go = prog_write_i & ~rst_i & addr_ok(prog_addr_i, IdxW);

    inst_mem_array #(
        .Depth    (Depth),
        .IdxW     (IdxW),
        .FillWord (FillWord)
    ) u_array (
        .clk_i   (clk_i),
        .we_i    (write_go),
        .waddr_i (prog_addr_i[IdxW+1:2]),
        .wdata_i (prog_data_i),
        .re_i    (fetch_go),
        .raddr_i (address_i[IdxW+1:2]),
        .rdata_o (ram_rdata)
    );

    always_comb begin
        valid_d = valid_q;
        fault_d = fault_q;
        blank_d = blank_q;
        count_d = count_q;
        if (!stall_i) begin
            valid_d = fetch_req_i;
            if (fetch_req_i) begin
                fault_d = ~addr_ok(address_i, IdxW);
                blank_d = 1'b0;
                count_d = count_q + CntW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            valid_q <= 1'b0;
            fault_q <= 1'b0;
            blank_q <= 1'b1;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            fault_q <= fault_d;
            blank_q <= blank_d;
            count_q <= count_d;
        end
    end

    // blank_q masks the RAM output register, which has no reset, until the first fetch.
    assign instruction_o = blank_q ? NopWord : (fault_q ? FillWord : ram_rdata);
    assign inst_valid_o  = valid_q;
    assign addr_fault_o  = fault_q;
    assign fetch_count_o = count_q;

endmodule

// File: doc/inst_fetch_mem.md
Name: inst_fetch_mem

Overview:
Parametrised, synchronous successor to the combinational instruction memory. Word-addressed storage indexed by byte address bits [IDX_W+1:2], with a registered read (1-cycle latency) and a fetch request/valid handshake with stall hold. Adds a program-load write port, alignment/range fault detection and a fetch counter. Sits between the PC register and the IF/ID pipeline register of the MIPS datapath.

Parameters:
DEPTH, 128, number of 32-bit instruction words (power of two, 16..4096)
IDX_W, 7, log2(DEPTH); index taken from Address[IDX_W+1:2]
FILL_WORD, 32'hFC000000, power-up content of every word and the instruction returned on fault
CNT_W, 16, width of FetchCount

Ports:
Clk  in  1  system clock, all state on rising edge
Reset  in  1  asynchronous, active-high reset
Address  in  32  byte address of requested instruction
FetchReq  in  1  fetch request this cycle
Stall  in  1  downstream stall; hold current output
ProgWrite  in  1  program-load write enable
ProgAddr  in  32  byte address for program load
ProgData  in  32  instruction word to load
Instruction  out  32  registered fetched instruction
InstValid  out  1  Instruction is valid
AddrFault  out  1  registered fault flag for the fetch in Instruction
FetchCount  out  CNT_W  number of completed fetches

Behaviour:
- Reset is asynchronous, active-high; on assertion: Instruction=32'h0, InstValid=0, AddrFault=0, FetchCount=0. Memory array is not reset; holds FILL_WORD from elaboration or last load.
- Reset mid-operation: an in-flight fetch is discarded; first fetch after deassertion behaves as from idle.
- Priority per cycle: Reset > Stall > FetchReq.
- Stall=1 and InstValid=1: Instruction, InstValid, AddrFault, FetchCount hold; FetchReq ignored (requester must re-present it).
- Stall=1 and InstValid=0: outputs hold (idle); FetchReq ignored.
- Stall=0, FetchReq=1: at the next edge Instruction<=mem[Address[IDX_W+1:2]], InstValid<=1, FetchCount<=FetchCount+1 (wraps modulo 2^CNT_W). Latency exactly 1 cycle; back-to-back fetches every cycle.
- Stall=0, FetchReq=0: InstValid<=0; Instruction and AddrFault hold their last values.
- Fault: Address[1:0]!=0 or Address[31:IDX_W+2]!=0 gives AddrFault<=1 and Instruction<=FILL_WORD; still counts as a fetch, InstValid<=1.
- ProgWrite=1: mem[ProgAddr[IDX_W+1:2]]<=ProgData on the edge, independent of fetch and stall. A misaligned or out-of-range ProgAddr is silently dropped.
- Same-cycle write and fetch to the same index: fetch returns the OLD word (read-before-write); the new word is visible from the following cycle.
- Reset does not block memory writes conceptually, but ProgWrite must be ignored while Reset=1.

Decomposition:
- Shared package: FILL_WORD default (HALT encoding 32'hFC000000), NOP_WORD 32'h0, and an index-extract/fault-check function.
- One sub-module, inst_mem_array: a single-write/single-read synchronous RAM of DEPTH x 32 with elaboration-time FILL_WORD init. The top handles the handshake, fault logic and counter.

Test Plan:
- Reset, then FetchReq at 0x0 with no loads -> next cycle Instruction=32'hFC000000, InstValid=1, AddrFault=0, FetchCount=1.
- Load 0x00008820 at ProgAddr 0x4, then fetch 0x4 -> Instruction=32'h00008820 one cycle later; fetches of 0x0, 0x4, 0x8 on consecutive cycles -> 3 valid outputs in 3 cycles, FetchCount=3.
- Fetch 0x4 then Stall=1 for 3 cycles while FetchReq=1 at 0x8 -> Instruction stays 32'h00008820 with InstValid=1 and FetchCount unchanged; after Stall drops, one cycle later the 0x8 word appears.
- Fetch 0x6 (misaligned) and 0x200 (out of range, DEPTH=128) -> AddrFault=1, Instruction=32'hFC000000; a write to ProgAddr 0x200 leaves every word unchanged.
- Same cycle: ProgWrite 0x20 with 32'h214A0004 and fetch 0x20 -> old 32'hFC000000 returned; the next fetch of 0x20 returns 32'h214A0004.
- Assert Reset asynchronously mid-stream between edges -> outputs go to zero immediately; preset FetchCount to 16'hFFFF, then one fetch -> wraps to 0.
